muldiv_ctrl: RTL and testbench

MULDIV_CTRL -- requirements
Module: muldiv_ctrl

---
 rtl/muldiv_pkg.sv | 29 ++
 rtl/muldiv_ctrl.sv | 151 +++++++++++++++
 tb/tb_muldiv_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide issue controller: FSM states,
// instruction op codes and the default result timeout.
package muldiv_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_MBUSY  = 3'd1,
        ST_DBUSY  = 3'd2,
        ST_DONE   = 3'd3,
        ST_CANCEL = 3'd4
    } md_state_e;

    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    localparam int MD_TIMEOUT = 63;

    // op[1] selects the divider, op[0] marks the unsigned flavour
    function automatic logic md_is_div(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic logic md_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/muldiv_ctrl.sv
// EX-stage controller that issues one MULT/DIV to the external units, stalls the
// pipeline until the result is captured, and handles flush, cancel and timeout.
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int TIMEOUT = MD_TIMEOUT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_i,
    input  logic [1:0]  op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        flush_i,
    input  logic        stall_ext_i,
    output logic        stall_o,
    output logic [63:0] result_o,
    output logic        result_valid_o,
    output logic        mult_opn_valid_o,
    output logic        mult_sign_o,
    output logic        mult_res_ready_o,
    input  logic        mult_res_valid_i,
    input  logic [63:0] mult_result_i,
    output logic        div_opn_valid_o,
    output logic        div_sign_o,
    output logic        div_res_ready_o,
    input  logic        div_res_valid_i,
    input  logic [63:0] div_result_i,
    output logic [31:0] opa_o,
    output logic [31:0] opb_o,
    output logic        timeout_err_o
);

    localparam int CW = $clog2(TIMEOUT + 1);

    md_state_e   state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic [31:0] opa_q, opa_d, opb_q, opb_d;
    logic [63:0] result_q, result_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic        err_q, err_d;

    logic        unit_div, unit_act, res_ready, res_valid, tmo;
    logic [63:0] res_data;

    assign unit_div  = md_is_div(op_q);
    assign res_valid = unit_div ? div_res_valid_i : mult_res_valid_i;
    assign res_data  = unit_div ? div_result_i : mult_result_i;
    // this is the TIMEOUT-th busy cycle without a result
    assign tmo       = (cnt_q == CW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            op_q     <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        op_d           = op_q;
        opa_d          = opa_q;
        opb_d          = opb_q;
        result_d       = result_q;
        cnt_d          = cnt_q;
        err_d          = err_q;
        stall_o        = 1'b0;
        result_valid_o = 1'b0;
        unit_act       = 1'b0;
        res_ready      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_i && !flush_i) begin
                    stall_o = 1'b1;
                    op_d    = op_i;
                    opa_d   = a_i;
                    opb_d   = b_i;
                    cnt_d   = '0;
                    state_d = md_is_div(op_i) ? ST_DBUSY : ST_MBUSY;
                end
            end
            ST_MBUSY, ST_DBUSY: begin
                unit_act = 1'b1;
                stall_o  = 1'b1;
                cnt_d    = cnt_q + 1'b1;
                if (res_valid) begin
                    res_ready = 1'b1;
                    if (flush_i) begin
                        stall_o = 1'b0;
                        state_d = ST_IDLE;
                    end else begin
                        result_d = res_data;
                        state_d  = ST_DONE;
                    end
                end else if (tmo) begin
                    err_d   = 1'b1;
                    stall_o = 1'b0;
                    state_d = ST_IDLE;
                end else if (flush_i) begin
                    stall_o = 1'b0;
                    state_d = ST_CANCEL;
                end
            end
            ST_CANCEL: begin
                // unit still owns the killed op; hold off any new instruction until it drains
                unit_act = 1'b1;
                stall_o  = req_i;
                cnt_d    = cnt_q + 1'b1;
                if (res_valid) begin
                    res_ready = 1'b1;
                    state_d   = ST_IDLE;
                end else if (tmo) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_DONE: begin
                result_valid_o = 1'b1;
                if (!stall_ext_i || flush_i) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign mult_opn_valid_o = unit_act & ~unit_div;
    assign mult_sign_o      = mult_opn_valid_o & md_is_signed(op_q);
    assign mult_res_ready_o = res_ready & ~unit_div;
    assign div_opn_valid_o  = unit_act & unit_div;
    assign div_sign_o       = div_opn_valid_o & md_is_signed(op_q);
    assign div_res_ready_o  = res_ready & unit_div;

    assign result_o      = result_q;
    assign opa_o         = opa_q;
    assign opb_o         = opb_q;
    assign timeout_err_o = err_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Bench for muldiv_ctrl: behavioural mult/div unit models, a vector table,
// hand-written flush/cancel/timeout/reset sequences and randomized operations.
module tb_muldiv_ctrl;
    import muldiv_pkg::*;

    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_i = 1'b0, flush_i = 1'b0, stall_ext_i = 1'b0;
    logic [1:0]  op_i = 2'b00;
    logic [31:0] a_i = '0, b_i = '0;
    logic        stall_o, result_valid_o, timeout_err_o;
    logic [63:0] result_o;
    logic        mult_opn_valid_o, mult_sign_o, mult_res_ready_o, mult_res_valid_i;
    logic        div_opn_valid_o, div_sign_o, div_res_ready_o, div_res_valid_i;
    logic [63:0] mult_result_i, div_result_i;
    logic [31:0] opa_o, opb_o;

    int n_cmp = 0, n_bad = 0;
    int mlat = 0, dlat = 0, mcnt = 0, dcnt = 0;
    bit mnever = 0, dnever = 0;

    muldiv_ctrl #(.TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .req_i(req_i), .op_i(op_i), .a_i(a_i), .b_i(b_i),
        .flush_i(flush_i), .stall_ext_i(stall_ext_i), .stall_o(stall_o),
        .result_o(result_o), .result_valid_o(result_valid_o),
        .mult_opn_valid_o(mult_opn_valid_o), .mult_sign_o(mult_sign_o),
        .mult_res_ready_o(mult_res_ready_o), .mult_res_valid_i(mult_res_valid_i),
        .mult_result_i(mult_result_i),
        .div_opn_valid_o(div_opn_valid_o), .div_sign_o(div_sign_o),
        .div_res_ready_o(div_res_ready_o), .div_res_valid_i(div_res_valid_i),
        .div_result_i(div_result_i),
        .opa_o(opa_o), .opb_o(opb_o), .timeout_err_o(timeout_err_o)
    );

    always #5 clk = ~clk;

    // Architectural result: {hi,lo}; divide gives {remainder, quotient}, x/0 -> {x, all-ones}
    function automatic logic [63:0] ref_res(input logic [1:0] o, input logic [31:0] x,
                                            input logic [31:0] y);
        longint sx, sy, q, r;
        logic [63:0] res;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (o)
            MD_MULT:  res = 64'(sx * sy);
            MD_MULTU: res = {32'b0, x} * {32'b0, y};
            MD_DIV: begin
                if (y == 0) res = {x, 32'hFFFF_FFFF};
                else begin
                    q = sx / sy;
                    r = sx % sy;
                    res = {r[31:0], q[31:0]};
                end
            end
            default: res = (y == 0) ? {x, 32'hFFFF_FFFF} : {x % y, x / y};
        endcase
        return res;
    endfunction

    // Unit models: result appears after lat cycles of opn_valid, computed from the shared operands
    assign mult_res_valid_i = mult_opn_valid_o && !mnever && (mcnt == mlat);
    assign div_res_valid_i  = div_opn_valid_o && !dnever && (dcnt == dlat);
    assign mult_result_i    = ref_res({1'b0, ~mult_sign_o}, opa_o, opb_o);
    assign div_result_i     = ref_res({1'b1, ~div_sign_o}, opa_o, opb_o);

    always @(posedge clk) begin
        if (rst || !mult_opn_valid_o || (mult_res_valid_i && mult_res_ready_o)) mcnt <= 0;
        else mcnt <= mcnt + 1;
        if (rst || !div_opn_valid_o || (div_res_valid_i && div_res_ready_o)) dcnt <= 0;
        else dcnt <= dcnt + 1;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // One full transaction: issue, wait for the stall to drop, hold DONE for `hold` extra cycles
    task automatic run_op(input string nm, input logic [1:0] o, input logic [31:0] x,
                          input logic [31:0] y, input int lat, input int hold,
                          input logic [63:0] exp);
        int n, eps, bad, vcnt;
        logic ov, prev_ov;
        bit done;
        cyc();
        mlat = lat; dlat = lat; mnever = 0; dnever = 0;
        req_i = 1'b1; op_i = o; a_i = x; b_i = y; flush_i = 1'b0;
        stall_ext_i = (hold > 0);
        @(negedge clk);
        chk({nm, ".issue_stall"}, 64'(stall_o), 64'd1);
        n = 1; eps = 0; bad = 0; prev_ov = 1'b0; done = 0;
        for (int k = 0; k < 100 && !done; k++) begin
            cyc();
            @(negedge clk);
            ov = mult_opn_valid_o | div_opn_valid_o;
            if (ov && !prev_ov) eps++;
            prev_ov = ov;
            if (!stall_o) done = 1;
            else begin
                n++;
                if (o[1]) begin
                    if (!div_opn_valid_o || div_sign_o != !o[0] || mult_opn_valid_o ||
                        mult_sign_o || mult_res_ready_o || div_res_ready_o != div_res_valid_i)
                        bad++;
                end else begin
                    if (!mult_opn_valid_o || mult_sign_o != !o[0] || div_opn_valid_o ||
                        div_sign_o || div_res_ready_o || mult_res_ready_o != mult_res_valid_i)
                        bad++;
                end
            end
        end
        if (!done) chk({nm, ".stall_bound"}, 64'd0, 64'd1);
        chk({nm, ".stall_cycles"}, 64'(n), 64'(lat + 2));
        chk({nm, ".handshake"}, 64'(bad), 64'd0);
        chk({nm, ".result_valid"}, 64'(result_valid_o), 64'd1);
        chk({nm, ".result"}, result_o, exp);
        vcnt = 1;
        for (int h = 0; h < hold; h++) begin
            cyc();
            if (h == hold - 1) stall_ext_i = 1'b0;
            @(negedge clk);
            if (mult_opn_valid_o | div_opn_valid_o) eps++;
            if (result_valid_o && !stall_o && result_o === exp) vcnt++;
        end
        cyc();
        req_i = 1'b0;
        @(negedge clk);
        chk({nm, ".valid_cycles"}, 64'(vcnt), 64'(hold + 1));
        chk({nm, ".opn_episodes"}, 64'(eps), 64'd1);
        chk({nm, ".valid_after"}, 64'(result_valid_o), 64'd0);
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a, b;
        int          lat, hold;
        logic [63:0] exp;
    } vec_t;

    vec_t tv[6];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int bad, seen, rdy, vbad;
        logic [1:0] ro;
        logic [31:0] rx, ry;

        tv[0] = '{MD_MULT,  32'hFFFF_FFFE, 32'd3,         4, 0, 64'hFFFF_FFFF_FFFF_FFFA};
        tv[1] = '{MD_DIVU,  32'd100,       32'd7,         3, 3, 64'h0000_0002_0000_000E};
        tv[2] = '{MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, 0, 64'hFFFF_FFFE_0000_0001};
        tv[3] = '{MD_DIV,   32'hFFFF_FFF9, 32'd2,         1, 1, 64'hFFFF_FFFF_FFFF_FFFD};
        tv[4] = '{MD_DIVU,  32'd5,         32'd0,         0, 0, 64'h0000_0005_FFFF_FFFF};
        tv[5] = '{MD_MULT,  32'h8000_0000, 32'h8000_0000, 5, 2, 64'h4000_0000_0000_0000};

        // reset state
        repeat (2) cyc();
        @(negedge clk);
        chk("rst_ctrl", 64'({stall_o, result_valid_o, mult_opn_valid_o, mult_sign_o,
                              mult_res_ready_o, div_opn_valid_o, div_sign_o,
                              div_res_ready_o, timeout_err_o}), 64'd0);
        chk("rst_data", {result_o, opa_o, opb_o} == '0, 64'd1);
        cyc();
        rst = 1'b0;

        for (int i = 0; i < 6; i++)
            run_op($sformatf("vec%0d", i), tv[i].op, tv[i].a, tv[i].b, tv[i].lat,
                   tv[i].hold, tv[i].exp);

        // flush while idle: no issue
        cyc();
        req_i = 1'b1; flush_i = 1'b1; op_i = MD_MULT; a_i = 32'd9; b_i = 32'd9;
        @(negedge clk);
        chk("idle_flush_stall", 64'(stall_o), 64'd0);
        cyc();
        req_i = 1'b0; flush_i = 1'b0;
        @(negedge clk);
        chk("idle_flush_noissue", 64'(mult_opn_valid_o | div_opn_valid_o), 64'd0);

        // flush during DIV: cancel, drain and discard the result
        cyc();
        dlat = 6; dnever = 0; req_i = 1'b1; op_i = MD_DIV; a_i = 32'hFFFF_FFEC; b_i = 32'd3;
        @(negedge clk);
        cyc();
        @(negedge clk);
        chk("fl_busy_stall", 64'(stall_o), 64'd1);
        cyc();
        flush_i = 1'b1; req_i = 1'b0;
        @(negedge clk);
        chk("fl_flush_stall", 64'(stall_o), 64'd0);
        cyc();
        flush_i = 1'b0;
        @(negedge clk);
        chk("fl_cancel_stall", 64'(stall_o), 64'd0);
        chk("fl_cancel_opn", 64'(div_opn_valid_o), 64'd1);
        seen = 0; rdy = 0; vbad = 0;
        for (int k = 0; k < 20 && seen == 0; k++) begin
            if (result_valid_o) vbad++;
            if (div_res_valid_i) begin
                seen = 1;
                rdy = int'(div_res_ready_o);
            end
            cyc();
            @(negedge clk);
        end
        chk("fl_res_seen", 64'(seen), 64'd1);
        chk("fl_res_ready", 64'(rdy), 64'd1);
        chk("fl_no_valid", 64'(vbad + int'(result_valid_o)), 64'd0);
        chk("fl_idle_opn", 64'(div_opn_valid_o), 64'd0);

        // new MULTU arrives while a cancelled DIV drains
        cyc();
        dlat = 5; mlat = 2; req_i = 1'b1; op_i = MD_DIV; a_i = 32'd50; b_i = 32'd4;
        @(negedge clk);
        cyc();
        cyc();
        flush_i = 1'b1; req_i = 1'b0;
        @(negedge clk);
        cyc();
        flush_i = 1'b0; req_i = 1'b1; op_i = MD_MULTU; a_i = 32'h8000_0001; b_i = 32'd6;
        bad = 0; seen = 0;
        for (int k = 0; k < 20 && seen == 0; k++) begin
            @(negedge clk);
            if (div_res_valid_i) seen = 1;
            if (!stall_o || mult_opn_valid_o || result_valid_o) bad++;
            if (seen == 0) cyc();
        end
        chk("cx_cancel_hold", 64'(bad), 64'd0);
        chk("cx_drained", 64'(seen), 64'd1);
        cyc();
        @(negedge clk);
        chk("cx_issue_stall", 64'(stall_o), 64'd1);
        bad = 0; seen = 0;
        for (int k = 0; k < 20 && seen == 0; k++) begin
            cyc();
            @(negedge clk);
            if (!stall_o) seen = 1;
            else if (!mult_opn_valid_o || mult_sign_o) bad++;
        end
        chk("cx_mult_unsigned", 64'(bad), 64'd0);
        chk("cx_done", 64'(seen), 64'd1);
        chk("cx_result", result_o, ref_res(MD_MULTU, 32'h8000_0001, 32'd6));
        chk("cx_valid", 64'(result_valid_o), 64'd1);
        cyc();
        req_i = 1'b0;

        // timeout: unit never answers
        cyc();
        mnever = 1; req_i = 1'b1; op_i = MD_MULT; a_i = 32'd5; b_i = 32'd6;
        @(negedge clk);
        bad = 0;
        for (int c = 1; c <= TMO; c++) begin
            cyc();
            @(negedge clk);
            if (stall_o != (c < TMO)) bad++;
            if (timeout_err_o) bad++;
        end
        chk("tmo_stall_pattern", 64'(bad), 64'd0);
        cyc();
        req_i = 1'b0;
        @(negedge clk);
        chk("tmo_err_set", 64'(timeout_err_o), 64'd1);
        chk("tmo_idle", 64'({stall_o, mult_opn_valid_o}), 64'd0);
        run_op("post_tmo", MD_MULTU, 32'd7, 32'd9, 1, 0, 64'd63);
        chk("tmo_sticky", 64'(timeout_err_o), 64'd1);
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        @(negedge clk);
        chk("tmo_cleared", 64'(timeout_err_o), 64'd0);

        // reset in the middle of a DIV
        cyc();
        dlat = 5; dnever = 0; req_i = 1'b1; op_i = MD_DIV; a_i = 32'd1000; b_i = 32'd3;
        @(negedge clk);
        cyc();
        @(negedge clk);
        chk("rb_busy", 64'(div_opn_valid_o), 64'd1);
        cyc();
        rst = 1'b1; req_i = 1'b0;
        cyc();
        rst = 1'b0;
        @(negedge clk);
        chk("rb_ctrl", 64'({stall_o, result_valid_o, mult_opn_valid_o, mult_sign_o,
                             mult_res_ready_o, div_opn_valid_o, div_sign_o,
                             div_res_ready_o, timeout_err_o}), 64'd0);
        chk("rb_data", {result_o, opa_o, opb_o} == '0, 64'd1);

        // randomized operations against the reference model
        for (int i = 0; i < 24; i++) begin
            ro = 2'($urandom_range(0, 3));
            rx = $urandom;
            ry = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            run_op($sformatf("rnd%0d", i), ro, rx, ry, int'($urandom_range(0, 5)),
                   int'($urandom_range(0, 2)), ref_res(ro, rx, ry));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
